// File: rtl/square_list.sv
// Scans a captured board one square per cycle and lists the side-to-move's pieces.
// Optional attack-map capture is enabled by defining SQUARE_LIST_ATTACK_EN.
module square_list #(
   parameter int PIECE_WIDTH = 4,
   parameter int ROWS        = 8,
   parameter int COLS        = 8,
   parameter int MAX_ENTRIES = 32,
   localparam int N          = ROWS * COLS,
   localparam int SQ_BITS    = $clog2(N),
   localparam int CNT_BITS   = $clog2(MAX_ENTRIES + 1),
   localparam int IDX_BITS   = $clog2(MAX_ENTRIES),
   localparam int ENTRY_W    = 1 + PIECE_WIDTH + SQ_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     board_valid,
   input  logic [N*PIECE_WIDTH-1:0] board,
   input  logic                     white_to_move,
   input  logic                     attack_valid,
   input  logic [N-1:0]             attacked,
   input  logic                     clear,
   input  logic [IDX_BITS-1:0]      entry_index,
   output logic                     list_ready,
   output logic [CNT_BITS-1:0]      entry_count,
   output logic                     overflow,
   output logic [ENTRY_W-1:0]       entry_data
);

   typedef enum logic [1:0] {StIdle, StWaitAttack, StScan, StDone} state_e;

   localparam logic [SQ_BITS-1:0]  LAST_SQ = SQ_BITS'(N - 1);
   localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_ENTRIES);

   state_e                   r_state;
   logic                     r_ready;
   logic [CNT_BITS-1:0]      r_count;
   logic                     r_ovf;
   logic [SQ_BITS-1:0]       r_sq;
   logic [N*PIECE_WIDTH-1:0] r_board;
   logic                     r_white;
   logic [ENTRY_W-1:0]       r_data;
   logic [ENTRY_W-1:0]       r_ram [MAX_ENTRIES];

   logic [PIECE_WIDTH-1:0]   w_piece;
   logic                     w_match;
   logic                     w_att_bit;
   logic                     w_wr;

`ifdef SQUARE_LIST_ATTACK_EN
   logic [N-1:0] r_attacked;
   assign w_att_bit = r_attacked[r_sq];
`else
   logic w_unused_attack;
   assign w_unused_attack = ^{attack_valid, attacked};
   assign w_att_bit       = 1'b0;
`endif

   assign w_piece = r_board[int'(r_sq) * PIECE_WIDTH +: PIECE_WIDTH];
   // Listed side is the one whose colour bit equals !white_to_move.
   assign w_match = (w_piece != '0) && (w_piece[PIECE_WIDTH-1] == !r_white);
   assign w_wr    = reset && !clear && (r_state == StScan) && w_match && (r_count < MAX_CNT);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_state <= StIdle;
         r_ready <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_sq    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (board_valid) begin
                  r_board <= board;
                  r_white <= white_to_move;
                  r_sq    <= '0;
`ifdef SQUARE_LIST_ATTACK_EN
                  r_state <= StWaitAttack;
`else
                  r_state <= StScan;
`endif
               end
            end
            StWaitAttack: begin
`ifdef SQUARE_LIST_ATTACK_EN
               if (attack_valid) begin
                  r_attacked <= attacked;
                  r_sq       <= '0;
                  r_state    <= StScan;
               end
`else
               r_state <= StIdle;
`endif
            end
            StScan: begin
               if (w_match) begin
                  if (r_count < MAX_CNT) r_count <= r_count + CNT_BITS'(1);
                  else                   r_ovf   <= 1'b1;
               end
               r_sq <= r_sq + SQ_BITS'(1);
               if (r_sq == LAST_SQ) begin
                  r_state <= StDone;
                  r_ready <= 1'b1;
               end
            end
            StDone: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_ram[r_count[IDX_BITS-1:0]] <= {w_att_bit, w_piece, r_sq};
   end

   always_ff @(posedge clk) begin
      if (!reset)                                 r_data <= '0;
      else if (CNT_BITS'(entry_index) < r_count) r_data <= r_ram[entry_index];
      else                                        r_data <= '0;
   end

   assign list_ready  = r_ready;
   assign entry_count = r_count;
   assign overflow    = r_ovf;
   assign entry_data  = r_data;

endmodule

// File: tb/tb_square_list.sv
// Directed bench for square_list: a 32-deep and an 8-deep instance run side by side.
module tb_square_list;
   localparam int N  = 64;
   localparam int PW = 4;
   localparam int EW = 11;
`ifdef SQUARE_LIST_ATTACK_EN
   localparam int   LAT = N + 1;
   localparam logic ATT = 1'b1;
`else
   localparam int   LAT = N;
   localparam logic ATT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          board_valid = 1'b0;
   logic          white_to_move = 1'b1;
   logic          attack_valid = 1'b1;
   logic          clear = 1'b0;
   logic [N*PW-1:0] board = '0;
   logic [N*PW-1:0] init_board = '0;
   logic [N-1:0]  attacked = '0;
   logic [4:0]    idx = '0;
   logic [2:0]    idx8 = '0;
   logic          ready, ovf, ready8, ovf8;
   logic [5:0]    cnt;
   logic [3:0]    cnt8;
   logic [EW-1:0] data, data8;
   logic [EW-1:0] d, d8;
   int            errors = 0;
   int            checks = 0;

   typedef struct {
      int            idx;
      logic [EW-1:0] exp;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;

   square_list u_dut (
      .clk(clk), .reset(reset), .board_valid(board_valid), .board(board),
      .white_to_move(white_to_move), .attack_valid(attack_valid), .attacked(attacked),
      .clear(clear), .entry_index(idx), .list_ready(ready), .entry_count(cnt),
      .overflow(ovf), .entry_data(data)
   );

   square_list #(.MAX_ENTRIES(8)) u_dut8 (
      .clk(clk), .reset(reset), .board_valid(board_valid), .board(board),
      .white_to_move(white_to_move), .attack_valid(attack_valid), .attacked(attacked),
      .clear(clear), .entry_index(idx8), .list_ready(ready8), .entry_count(cnt8),
      .overflow(ovf8), .entry_data(data8)
   );

   function automatic logic [EW-1:0] ent(input logic att, input logic [3:0] pc,
                                         input logic [5:0] sq);
      return {att, pc, sq};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start();
      @(negedge clk);
      board_valid = 1'b1;
      @(posedge clk);
      #1 board_valid = 1'b0;
   endtask

   // exp_lat < 0 only requires completion within the bound.
   task automatic wait_ready(input string name, input int exp_lat);
      int n = 0;
      bit seen = 1'b0;
      while (n < 300 && !seen) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = ready;
      end
      if (exp_lat >= 0) check(name, n, exp_lat);
      else              check(name, seen, 1);
   endtask

   task automatic rd(input int i, output logic [EW-1:0] o, output logic [EW-1:0] o8);
      @(negedge clk);
      idx  = i[4:0];
      idx8 = i[2:0];
      @(posedge clk);
      @(negedge clk);
      o  = data;
      o8 = data8;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
      int n;
      for (int c = 0; c < 8; c++) begin
         init_board[c*PW +: PW]        = back[c][3:0];
         init_board[(8 + c)*PW +: PW]  = 4'd1;
         init_board[(48 + c)*PW +: PW] = 4'd9;
         init_board[(56 + c)*PW +: PW] = 4'd8 | back[c][3:0];
      end
      vt[0] = '{0,  ent(1'b0, 4'd4, 6'd0)};
      vt[1] = '{1,  ent(1'b0, 4'd2, 6'd1)};
      vt[2] = '{4,  ent(1'b0, 4'd6, 6'd4)};
      vt[3] = '{7,  ent(1'b0, 4'd4, 6'd7)};
      vt[4] = '{8,  ent(1'b0, 4'd1, 6'd8)};
      vt[5] = '{15, ent(1'b0, 4'd1, 6'd15)};
      vt[6] = '{16, '0};
      vt[7] = '{31, '0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst ready", ready, 0);
      check("rst count", cnt, 0);
      check("rst overflow", ovf, 0);
      check("rst data", data, 0);
      reset = 1'b1;

      // Initial position, white to move; board is trashed after capture
      board = init_board;
      white_to_move = 1'b1;
      start();
      board = '0;
      wait_ready("white latency", LAT);
      check("white count", cnt, 16);
      check("white overflow", ovf, 0);
      for (int i = 0; i < 8; i++) begin
         rd(vt[i].idx, d, d8);
         check($sformatf("white entry %0d", vt[i].idx), d, vt[i].exp);
      end
      check("max8 count", cnt8, 8);
      check("max8 overflow", ovf8, 1);
      rd(7, d, d8);
      check("max8 entry 7", d8, ent(1'b0, 4'd4, 6'd7));

      // Clear, then black to move with attacked squares
      do_clear();
      check("clear ready", ready, 0);
      check("clear count", cnt, 0);
      check("clear overflow8", ovf8, 0);
      board = init_board;
      white_to_move = 1'b0;
      attacked = '0;
      attacked[48] = 1'b1;
      attacked[63] = 1'b1;
      start();
      attacked = '0;
      wait_ready("black latency", LAT);
      check("black count", cnt, 16);
      rd(0, d, d8);
      check("black entry 0", d, ent(ATT, 4'd9, 6'd48));
      rd(1, d, d8);
      check("black entry 1", d, ent(1'b0, 4'd9, 6'd49));
      rd(15, d, d8);
      check("black entry 15", d, ent(ATT, 4'd12, 6'd63));

      // Clear and board_valid together in DONE: clear wins
      @(negedge clk);
      clear = 1'b1;
      board_valid = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      board_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("clr+bv ready", ready, 0);
      check("clr+bv count", cnt, 0);

      white_to_move = 1'b1;
      attack_valid = 1'b0;
      start();
`ifdef SQUARE_LIST_ATTACK_EN
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("attack wait count", cnt, 0);
      check("attack wait ready", ready, 0);
      attack_valid = 1'b1;
      wait_ready("attack release done", -1);
`else
      wait_ready("no-attack latency", LAT);
      attack_valid = 1'b1;
`endif
      check("rescan count", cnt, 16);
      rd(0, d, d8);
      check("rescan entry 0", d, ent(1'b0, 4'd4, 6'd0));

      // Reset mid-scan at square 5
      do_clear();
      start();
      n = 0;
      while (n < 200 && cnt != 6'd5) begin
         @(negedge clk);
         n++;
      end
      check("reach square 5", cnt, 5);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("midscan rst count", cnt, 0);
      check("midscan rst ready", ready, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("post rst count", cnt, 0);
      rd(0, d, d8);
      check("post rst read", d, 0);

      white_to_move = 1'b0;
      start();
      wait_ready("after rst latency", LAT);
      check("after rst count", cnt, 16);
      rd(0, d, d8);
      check("after rst entry 0", d, ent(1'b0, 4'd9, 6'd48));
      rd(8, d, d8);
      check("after rst entry 8", d, ent(1'b0, 4'd12, 6'd56));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
